uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 34 +++
 rtl/tx_bit_counter.sv | 82 ++++++++
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Constants shared by the UART transmitter: FSM state encoding, parity-type
// codes, the prescale field width, and the parity-bit helper.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Width of the Prescale field (clk cycles per bit period).
    localparam int PRESCALE_W = 5;

    // FSM state encoding, kept as plain constants for legacy tools.
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Parity type codes as seen on PAR_TYP.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Parity bit from the XOR-reduction of the data word: even parity sends
    // the reduction itself, odd parity sends its inverse.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        logic result;
        if (par_typ == PAR_ODD) begin
            result = ~data_xor;
        end else begin
            result = data_xor;
        end
        return result;
    endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// ---------------------------------------------------------------------------
// tx_bit_counter
// Per-bit edge counter and data-bit index counter for the UART transmitter.
//   clk, rst    : clock, synchronous active-high reset
//   active      : a frame is in progress (counters held at 0 otherwise)
//   data_phase  : the FSM is sending data bits (bit index advances)
//   prescale    : captured cycles-per-bit, 0 treated as 1
//   edge_cnt    : position inside the current bit period, 0..P-1
//   bit_cnt     : index of the data bit being sent, 0..DATA_WIDTH-1
//   bit_done    : high on the last cycle of the current bit period
// ---------------------------------------------------------------------------
module tx_bit_counter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic                  data_phase,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  bit_done
);

    logic [PRESCALE_W-1:0] edge_cnt_q;
    logic [PRESCALE_W-1:0] edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [BIT_W-1:0]      bit_cnt_d;
    logic [PRESCALE_W-1:0] last_edge_s;

    // Last count value of a bit period; Prescale=0 behaves like Prescale=1.
    always_comb begin
        if (prescale == {PRESCALE_W{1'b0}}) begin
            last_edge_s = {PRESCALE_W{1'b0}};
        end else begin
            last_edge_s = prescale - {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end

    assign bit_done = active && (edge_cnt_q == last_edge_s);

    // Next-state of the edge and bit-index counters.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (!active) begin
            edge_cnt_d = {PRESCALE_W{1'b0}};
            bit_cnt_d  = {BIT_W{1'b0}};
        end else if (bit_done) begin
            edge_cnt_d = {PRESCALE_W{1'b0}};
            if (data_phase) begin
                if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                    bit_cnt_d = {BIT_W{1'b0}};
                end else begin
                    bit_cnt_d = bit_cnt_q + {{(BIT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end else begin
            edge_cnt_d = edge_cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= {PRESCALE_W{1'b0}};
            bit_cnt_q  <= {BIT_W{1'b0}};
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, one stop bit. Each bit lasts Prescale clk cycles.
//   clk, rst   : clock, synchronous active-high reset
//   P_DATA     : parallel word to send, captured on Data_Valid in IDLE
//   Data_Valid : send request, ignored while a frame is in progress
//   PAR_EN     : 1 = insert parity bit
//   PAR_TYP    : 0 = even, 1 = odd parity
//   Prescale   : clk cycles per bit period (0 behaves as 1)
//   TX_OUT     : registered serial line, idle high
//   busy       : registered, high for the whole frame
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    logic [2:0]            state_q,    state_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic                  par_en_q,   par_en_d;
    logic                  par_bit_q,  par_bit_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  tx_q,       tx_d;
    logic                  busy_q,     busy_d;

    logic                  active_s;
    logic                  data_phase_s;
    logic                  bit_done_s;
    logic                  bit_last_s;
    logic [BIT_W-1:0]      bit_cnt_s;
    // The FSM only needs bit_done; the edge count is kept for observability.
    logic [PRESCALE_W-1:0] unused_edge_cnt_s;

    assign active_s     = (state_q != IDLE);
    assign data_phase_s = (state_q == DATA);
    assign bit_last_s   = (bit_cnt_s == BIT_W'(DATA_WIDTH - 1));

    tx_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .active     (active_s),
        .data_phase (data_phase_s),
        .prescale   (prescale_q),
        .edge_cnt   (unused_edge_cnt_s),
        .bit_cnt    (bit_cnt_s),
        .bit_done   (bit_done_s)
    );

    // FSM next-state; TX_OUT/busy are computed for the next cycle so that
    // both leave flops with no combinational path to the pins.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        prescale_d = prescale_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d    = START;
                    shift_d    = P_DATA;
                    par_en_d   = PAR_EN;
                    // Parity is frozen at capture because the shift
                    // register is consumed as the bits go out.
                    par_bit_d  = parity_bit(^P_DATA, PAR_TYP);
                    prescale_d = Prescale;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            end
            START: begin
                if (bit_done_s) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    if (bit_last_s) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (bit_done_s) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (bit_done_s) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, captured frame parameters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= {DATA_WIDTH{1'b0}};
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            prescale_q <= {PRESCALE_W{1'b0}};
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            prescale_q <= prescale_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Scoreboard bench for uart_tx. The driver turns each request into the
// expected line level for every busy cycle plus the expected busy length;
// a monitor on the falling clock edge pops and compares.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic [4:0] prescale;
    logic       tx_out;
    logic       busy;

    int tests = 0;
    int fails = 0;
    bit monitor_en = 1'b0;

    logic exp_q[$];   // expected TX_OUT for each busy cycle
    int   len_q[$];   // expected busy length per frame

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (p_data),
        .Data_Valid (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .Prescale   (prescale),
        .TX_OUT     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: list the frame's bits, then repeat each P times.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic [4:0] ps);
        int   p;
        int   ones;
        logic bits[$];
        p    = (ps == 5'd0) ? 1 : int'(ps);
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) begin
            // even: 1 when the count of ones is odd; odd type inverts
            bits.push_back(((ones % 2) == 1) ^ pt);
        end
        bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int r = 0; r < p; r++) exp_q.push_back(bits[b]);
        end
        len_q.push_back(bits.size() * p);
    endtask

    // Issue one request, then scramble the inputs while the frame runs.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [4:0] ps);
        @(posedge clk); #1;
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = ps;
        data_valid = 1'b1;
        push_frame(d, pe, pt, ps);
        @(posedge clk); #1;
        data_valid = 1'b0;
        p_data     = 8'($urandom);
        par_en     = 1'($urandom);
        par_typ    = 1'($urandom);
        prescale   = 5'($urandom);
    endtask

    // Bounded wait for the scoreboard to drain, plus idle gap.
    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: compare the line every busy cycle, idle level otherwise.
    int   run_len   = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (monitor_en) begin
            if (busy === 1'b1) begin
                run_len++;
                if (exp_q.size() == 0) begin
                    check("unexpected_busy", 1, 0);
                end else begin
                    check("tx_bit", tx_out, exp_q.pop_front());
                end
            end else begin
                check("idle_tx", tx_out, 1);
                if (prev_busy === 1'b1) begin
                    if (len_q.size() != 0) check("busy_len", run_len, len_q.pop_front());
                    if (exp_q.size() != 0) begin
                        check("frame_short", exp_q.size(), 0);
                        exp_q.delete();
                    end
                end
                run_len = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        data_valid = 1'b0;
        p_data     = 8'h00;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = 5'd1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", tx_out, 1);
        check("reset_busy", busy, 0);
        monitor_en = 1'b1;

        // Directed frames
        send(8'hA5, 1'b1, 1'b0, 5'd8);  wait_idle();   // parity 0, 88 cycles
        send(8'hA5, 1'b1, 1'b1, 5'd8);  wait_idle();   // parity 1
        send(8'h00, 1'b0, 1'b0, 5'd1);  wait_idle();   // 10 cycles
        send(8'h3C, 1'b0, 1'b0, 5'd0);  wait_idle();   // Prescale 0 as 1
        send(8'h3C, 1'b0, 1'b0, 5'd1);  wait_idle();

        // Data_Valid mid-frame must be ignored
        send(8'h5A, 1'b1, 1'b0, 5'd3);
        repeat (10) @(posedge clk);
        #1;
        p_data     = 8'hFF;
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        wait_idle();
        repeat (40) @(posedge clk);
        #1;
        check("no_second_frame_busy", busy, 0);

        // Reset during the third data bit (P=4: cycles 13..16 after capture)
        send(8'h96, 1'b1, 1'b1, 5'd4);
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        len_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("midreset_tx", tx_out, 1);
        check("midreset_busy", busy, 0);
        send(8'hC3, 1'b1, 1'b0, 5'd2);  wait_idle();

        // Randomized frames
        for (int n = 0; n < 20; n++) begin
            send(8'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 6)));
            wait_idle();
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
